// File: rtl/main_mem.sv
// main_mem: backing store that sits behind the data cache on its mem_* port.
// It serves single-word and whole-block (burst) reads and writes after a
// programmable access latency, one transaction at a time.
module main_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_WORDS  = 4096,
   parameter int BLOCK_SIZE = 128,
   parameter int LATENCY    = 10,
   // Optional preload image. The array has no reset and no initial block;
   // any preload of mem_array is left to the surrounding environment.
   parameter     INIT_FILE  = ""
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic                  mem_burst,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_din,
   output logic [DATA_WIDTH-1:0] mem_dout,
   output logic                  mem_rdy,
   output logic                  mem_dvalid,
   output logic                  mem_wack
);

   localparam int BEATS  = BLOCK_SIZE * 8 / DATA_WIDTH;
   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [LAT_W-1:0]  LAT_INIT   = LAT_W'(LATENCY - 1);
   localparam logic [BEAT_W-1:0] LAST_BURST = BEAT_W'(BEATS - 1);
   localparam logic [IDX_W-1:0]  BLK_MASK   = ~IDX_W'(BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RBURST,
      ST_WBURST
   } state_t;

   state_t                  state;
   logic                    is_write;
   logic                    burst;
   logic [IDX_W-1:0]        base;
   logic [LAT_W-1:0]        lat_cnt;
   logic [BEAT_W-1:0]       beat;
   logic [DATA_WIDTH-1:0]   mem_array [MEM_WORDS];

   logic [IDX_W-1:0]        req_idx;
   logic [IDX_W-1:0]        beat_idx;
   logic [IDX_W-1:0]        next_idx;
   logic [BEAT_W-1:0]       last_beat;
   logic                    unused_addr;

   // Word index ignores the two byte-offset bits; upper bits alias.
   assign req_idx     = mem_addr[2 +: IDX_W];
   // Base is block aligned, so base+beat never carries out of the block.
   assign beat_idx    = base + IDX_W'(beat);
   assign next_idx    = beat_idx + IDX_W'(1);
   assign last_beat   = burst ? LAST_BURST : '0;
   assign unused_addr = ^{mem_addr[ADDR_WIDTH-1:IDX_W+2], mem_addr[1:0]};

   // Transaction controller: accept, count latency, then stream beats.
   always_ff @(posedge clk) begin
      // NOTE: all state and registered outputs use <= so every branch sees
      // the pre-edge values, independent of statement order.
      if (rst) begin
         state      <= ST_IDLE;
         mem_rdy    <= 1'b1;
         mem_dvalid <= 1'b0;
         mem_wack   <= 1'b0;
         mem_dout   <= '0;
         lat_cnt    <= '0;
         beat       <= '0;
         is_write   <= 1'b0;
         burst      <= 1'b0;
         base       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_ren || mem_wen) begin
                  // A simultaneous read and write is taken as a write.
                  is_write <= mem_wen;
                  burst    <= mem_burst;
                  base     <= mem_burst ? (req_idx & BLK_MASK) : req_idx;
                  lat_cnt  <= LAT_INIT;
                  mem_rdy  <= 1'b0;
                  state    <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  beat <= '0;
                  if (is_write) begin
                     mem_wack <= 1'b1;
                     state    <= ST_WBURST;
                  end else begin
                     mem_dvalid <= 1'b1;
                     mem_dout   <= mem_array[base];
                     state      <= ST_RBURST;
                  end
               end else begin
                  lat_cnt <= lat_cnt - LAT_W'(1);
               end
            end

            ST_RBURST: begin
               if (beat == last_beat) begin
                  mem_dvalid <= 1'b0;
                  mem_rdy    <= 1'b1;
                  beat       <= '0;
                  state      <= ST_IDLE;
               end else begin
                  beat     <= beat + BEAT_W'(1);
                  mem_dout <= mem_array[next_idx];
               end
            end

            ST_WBURST: begin
               if (beat == last_beat) begin
                  mem_wack <= 1'b0;
                  mem_rdy  <= 1'b1;
                  beat     <= '0;
                  state    <= ST_IDLE;
               end else begin
                  beat <= beat + BEAT_W'(1);
               end
            end

            default: begin
               state   <= ST_IDLE;
               mem_rdy <= 1'b1;
            end
         endcase
      end
   end

   // Storage array: one word written per acknowledged write beat.
   always_ff @(posedge clk) begin
      // NOTE: the array is deliberately not reset; a reset only aborts the
      // transfer, and clearing RAM would prevent mapping it to block memory.
      if (!rst && mem_wack) begin
         mem_array[beat_idx] <= mem_din;
      end
   end

endmodule

// File: tb/tb_main_mem.sv
// tb_main_mem: randomized self-checking bench for main_mem at default
// parameters, compared against a word-array model of the store.
module tb_main_mem;

   localparam int LATENCY = 10;
   localparam int WORDS   = 4096;
   localparam int BEATS   = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_ren;
   logic        mem_wen;
   logic        mem_burst;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic        mem_rdy;
   logic        mem_dvalid;
   logic        mem_wack;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: word store plus a record of which words were written.
   logic [31:0] model [WORDS];
   bit          known [WORDS];
   logic [31:0] wbuf  [BEATS];

   // Observations of the last transaction.
   int          t_e0, t_first, t_last, t_n, t_gap, t_cross, t_rdy_busy;
   bit          t_aborted;
   logic        t_rdy_after, t_strobe_after;
   logic [31:0] t_dout_after;
   logic [31:0] rd_q [$];

   main_mem #(.LATENCY(LATENCY)) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ren    (mem_ren),
      .mem_wen    (mem_wen),
      .mem_burst  (mem_burst),
      .mem_addr   (mem_addr),
      .mem_din    (mem_din),
      .mem_dout   (mem_dout),
      .mem_rdy    (mem_rdy),
      .mem_dvalid (mem_dvalid),
      .mem_wack   (mem_wack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Word a beat of a transaction touches, from the address rules.
   function automatic int widx(input logic [31:0] a, input logic b, input int k);
      logic [31:0] w;
      w = a >> 2;
      if (b) w = (w & ~32'd31) + 32'(k);
      return int'(w % 32'(WORDS));
   endfunction

   // Issue one request from an idle DUT and record what comes back.
   task automatic run_txn(input logic w, input logic r, input logic b,
                          input logic [31:0] a, input logic hold_busy,
                          input int abort_at);
      int   exp_n;
      logic strobe;
      exp_n = b ? BEATS : 1;
      mem_wen = w; mem_ren = r; mem_burst = b; mem_addr = a; mem_din = $urandom;
      t_e0 = cyc + 1;
      t_first = -1; t_last = -1; t_n = 0; t_gap = 0; t_cross = 0;
      t_rdy_busy = 0; t_aborted = 0;
      rd_q.delete();
      @(negedge clk);
      mem_wen = 1'b0; mem_ren = hold_busy;
      mem_burst = 1'($urandom); mem_addr = $urandom;
      for (int t = 0; t < 300; t++) begin
         strobe = w ? mem_wack : mem_dvalid;
         if ((w ? mem_dvalid : mem_wack) === 1'b1) t_cross++;
         if (mem_rdy !== 1'b0) t_rdy_busy++;
         if (strobe === 1'b1) begin
            if (t_first < 0) t_first = cyc;
            else if (cyc != t_last + 1) t_gap++;
            t_last = cyc;
            if (w) mem_din = wbuf[t_n];
            else rd_q.push_back(mem_dout);
            t_n++;
         end
         if (t_n == exp_n || (abort_at >= 0 && t_n == abort_at)) break;
         @(negedge clk);
      end
      mem_ren = 1'b0;
      if (abort_at >= 0 && t_n == abort_at) begin
         rst = 1'b1;
         t_aborted = 1'b1;
      end
      @(negedge clk);
      t_rdy_after    = mem_rdy;
      t_strobe_after = mem_dvalid | mem_wack;
      t_dout_after   = mem_dout;
      rst = 1'b0;
      if (w && !t_aborted)
         for (int k = 0; k < t_n; k++) begin
            model[widx(a, b, k)] = wbuf[k];
            known[widx(a, b, k)] = 1'b1;
         end
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_ren = 0; mem_wen = 0; mem_burst = 0; mem_addr = 0; mem_din = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({mem_rdy, mem_dvalid, mem_wack} !== 3'b100 || mem_dout !== 32'h0) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: rdy=%b dvalid=%b wack=%b dout=%h, need 1 0 0 00000000",
                     i, mem_rdy, mem_dvalid, mem_wack, mem_dout);
         end
      end
   endtask

   task automatic test_single();
      wbuf[0] = 32'hDEADBEEF;
      run_txn(1, 0, 0, 32'h0000_0104, 0, -1);
      checks++;
      if (t_n != 1 || t_first != t_e0 + LATENCY) begin
         errors++;
         $display("FAIL single_write_timing: beats=%0d first=%0d, need 1 at %0d", t_n, t_first, t_e0 + LATENCY);
      end
      checks++;
      if (t_cross != 0 || t_rdy_busy != 0 || t_rdy_after !== 1'b1) begin
         errors++;
         $display("FAIL single_write_handshake: dvalid=%0d rdy_busy=%0d rdy_after=%b, need 0 0 1", t_cross, t_rdy_busy, t_rdy_after);
      end
      run_txn(0, 1, 0, 32'h0000_0104, 0, -1);
      checks++;
      if (t_n != 1 || t_first != t_e0 + LATENCY || rd_q[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL single_read: beats=%0d first=%0d data=%h, need 1 at %0d data deadbeef",
                  t_n, t_first, (t_n > 0) ? rd_q[0] : 32'hx, t_e0 + LATENCY);
      end
      checks++;
      if (t_rdy_after !== 1'b1 || t_strobe_after !== 1'b0) begin
         errors++;
         $display("FAIL single_read_done: rdy=%b strobe=%b, need 1 0", t_rdy_after, t_strobe_after);
      end
   endtask

   task automatic test_burst();
      for (int k = 0; k < BEATS; k++) wbuf[k] = 32'h1000 + 32'(k);
      run_txn(1, 0, 1, 32'h0000_0210, 0, -1);
      checks++;
      if (t_n != BEATS || t_gap != 0 || t_first != t_e0 + LATENCY || t_cross != 0) begin
         errors++;
         $display("FAIL burst_write: beats=%0d gaps=%0d first=%0d dvalid=%0d, need 32 0 %0d 0",
                  t_n, t_gap, t_first, t_cross, t_e0 + LATENCY);
      end
      run_txn(0, 1, 1, 32'h0000_023C, 0, -1);
      checks++;
      if (t_n != BEATS || t_gap != 0 || t_first != t_e0 + LATENCY || t_rdy_after !== 1'b1) begin
         errors++;
         $display("FAIL burst_read_shape: beats=%0d gaps=%0d first=%0d rdy_after=%b, need 32 0 %0d 1",
                  t_n, t_gap, t_first, t_rdy_after, t_e0 + LATENCY);
      end
      for (int k = 0; k < t_n; k++) begin
         checks++;
         if (rd_q[k] !== 32'h1000 + 32'(k)) begin
            errors++;
            $display("FAIL burst_read_data beat %0d: got %h, need %h", k, rd_q[k], 32'h1000 + 32'(k));
         end
      end
   endtask

   task automatic test_both();
      wbuf[0] = 32'h5A5A5A5A;
      run_txn(1, 1, 0, 32'h0000_0040, 0, -1);
      checks++;
      if (t_n != 1 || t_cross != 0) begin
         errors++;
         $display("FAIL ren_wen_as_write: wack beats=%0d dvalid beats=%0d, need 1 0", t_n, t_cross);
      end
      run_txn(0, 1, 0, 32'h0000_0040, 0, -1);
      checks++;
      if (t_n != 1 || rd_q[0] !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL ren_wen_readback: beats=%0d data=%h, need 1 5a5a5a5a", t_n, (t_n > 0) ? rd_q[0] : 32'hx);
      end
   endtask

   task automatic test_alias_busy();
      int extra;
      wbuf[0] = 32'h11111111;
      // A read request is held high for the whole busy period.
      run_txn(1, 0, 0, 32'h0000_4000, 1, -1);
      checks++;
      if (t_n != 1 || t_cross != 0 || t_rdy_busy != 0) begin
         errors++;
         $display("FAIL busy_ignored: wack=%0d dvalid=%0d rdy_busy=%0d, need 1 0 0", t_n, t_cross, t_rdy_busy);
      end
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_dvalid === 1'b1 || mem_wack === 1'b1) extra++;
         @(negedge clk);
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL busy_not_queued: extra beats=%0d, need 0", extra);
      end
      run_txn(0, 1, 0, 32'h0000_0000, 0, -1);
      checks++;
      if (t_n != 1 || rd_q[0] !== 32'h11111111) begin
         errors++;
         $display("FAIL alias_read: beats=%0d data=%h, need 1 11111111", t_n, (t_n > 0) ? rd_q[0] : 32'hx);
      end
   endtask

   task automatic test_reset_mid();
      run_txn(0, 1, 1, 32'h0000_0200, 0, 5);
      checks++;
      if (!t_aborted || t_strobe_after !== 1'b0 || t_rdy_after !== 1'b1 || t_dout_after !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_burst: aborted=%0d dvalid=%b rdy=%b dout=%h, need 1 0 1 00000000",
                  t_aborted, t_strobe_after, t_rdy_after, t_dout_after);
      end
      for (int k = 0; k < t_n; k++) begin
         checks++;
         if (rd_q[k] !== model[widx(32'h200, 1, k)]) begin
            errors++;
            $display("FAIL reset_mid_data beat %0d: got %h, need %h", k, rd_q[k], model[widx(32'h200, 1, k)]);
         end
      end
      run_txn(0, 1, 0, 32'h0000_0104, 0, -1);
      checks++;
      if (t_n != 1 || t_first != t_e0 + LATENCY || rd_q[0] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL post_reset_read: beats=%0d first=%0d data=%h, need 1 at %0d deadbeef",
                  t_n, t_first, (t_n > 0) ? rd_q[0] : 32'hx, t_e0 + LATENCY);
      end
   endtask

   task automatic test_random();
      logic [31:0] a, ra;
      logic        b;
      int          wi;
      for (int it = 0; it < 10; it++) begin
         a = $urandom;
         b = 1'($urandom);
         for (int k = 0; k < BEATS; k++) wbuf[k] = $urandom;
         run_txn(1, 1'($urandom), b, a, 1'($urandom), -1);
         checks++;
         if (t_n != (b ? BEATS : 1) || t_gap != 0 || t_first != t_e0 + LATENCY) begin
            errors++;
            $display("FAIL rand_write %0d: beats=%0d gaps=%0d first=%0d, need %0d 0 %0d",
                     it, t_n, t_gap, t_first, b ? BEATS : 1, t_e0 + LATENCY);
         end
         // Read back the same block or word through a different alias.
         ra = a ^ (32'($urandom_range(1, 15)) << 14) ^ 32'($urandom_range(0, 3));
         if (b) ra = ra ^ (32'($urandom_range(0, 31)) << 2);
         run_txn(0, 1, b, ra, 0, -1);
         checks++;
         if (t_n != (b ? BEATS : 1) || t_gap != 0 || t_first != t_e0 + LATENCY || t_rdy_after !== 1'b1) begin
            errors++;
            $display("FAIL rand_read %0d: beats=%0d gaps=%0d first=%0d rdy_after=%b, need %0d 0 %0d 1",
                     it, t_n, t_gap, t_first, t_rdy_after, b ? BEATS : 1, t_e0 + LATENCY);
         end
         for (int k = 0; k < t_n; k++) begin
            wi = widx(ra, b, k);
            if (known[wi]) begin
               checks++;
               if (rd_q[k] !== model[wi]) begin
                  errors++;
                  $display("FAIL rand_read_data %0d beat %0d: got %h, need %h", it, k, rd_q[k], model[wi]);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_both();
      test_alias_busy();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
